// File: rtl/arb4to1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arb4to1 : 4-requester round-robin arbiter with registered owner-data mux.   |
// | Optional ARB4TO1_TIMEOUT_EN: rotate the grant after MAX_HOLD owner cycles.  |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module arb4to1 #(
  parameter int DATA_W   = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [3:0]        i_req,
  input  logic [DATA_W-1:0] i_0,
  input  logic [DATA_W-1:0] i_1,
  input  logic [DATA_W-1:0] i_2,
  input  logic [DATA_W-1:0] i_3,
  output logic [3:0]        o_gnt,
  output logic              o_sel1,
  output logic              o_sel0,
  output logic [DATA_W-1:0] o_y,
  output logic              o_valid
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  if (MAX_HOLD < 1) begin : g_max_hold_check
    $error("arb4to1: MAX_HOLD must be at least 1");
  end

  state_t            r_state;
  logic [1:0]        r_last_owner;
  logic [DATA_W-1:0] w_data [4];
  logic [3:0]        w_cand;
  logic [1:0]        w_idx;
  logic [1:0]        w_pick;
  logic              w_found;
  logic              w_owner_req;
  logic              w_rotate;

  assign w_data[0] = i_0;
  assign w_data[1] = i_1;
  assign w_data[2] = i_2;
  assign w_data[3] = i_3;

  // While granted, r_last_owner is the current owner; the owner is never a
  // candidate for its own successor.
  always_comb begin
    w_owner_req = i_req[r_last_owner];
    w_cand      = i_req;
    if (r_state == GRANT) begin
      w_cand[r_last_owner] = 1'b0;
    end
    w_found = 1'b0;
    w_pick  = r_last_owner;
    w_idx   = r_last_owner;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last_owner + 2'(k);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

`ifdef ARB4TO1_TIMEOUT_EN
  localparam int HOLD_W = ($clog2(MAX_HOLD) > 0) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  // r_hold counts completed owner cycles; it saturates while nobody competes.
  logic [HOLD_W-1:0] r_hold;
  assign w_rotate = (r_hold == C_HOLD_LAST) && w_found;
`else
  assign w_rotate = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_last_owner <= 2'd3;
      o_gnt        <= 4'b0000;
      o_sel1       <= 1'b0;
      o_sel0       <= 1'b0;
      o_y          <= '0;
      o_valid      <= 1'b0;
`ifdef ARB4TO1_TIMEOUT_EN
      r_hold       <= '0;
`endif
    end else begin
      o_valid <= 1'b0;
      if (r_state == GRANT && w_owner_req) begin
        o_valid <= 1'b1;
        o_y     <= w_data[r_last_owner];
      end

      if (r_state == GRANT && w_owner_req && !w_rotate) begin
`ifdef ARB4TO1_TIMEOUT_EN
        if (r_hold != C_HOLD_LAST) begin
          r_hold <= r_hold + 1'b1;
        end
`endif
      end else if (w_found) begin
        r_state              <= GRANT;
        r_last_owner         <= w_pick;
        o_gnt                <= 4'b0001 << w_pick;
        {o_sel1, o_sel0}     <= w_pick;
`ifdef ARB4TO1_TIMEOUT_EN
        r_hold               <= '0;
`endif
      end else begin
        r_state <= IDLE;
        o_gnt   <= 4'b0000;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arb4to1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_arb4to1 : self-checking bench for arb4to1 with a round-robin model.      |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_arb4to1;

  localparam int DW       = 2;
  localparam int MAX_HOLD = 8;
`ifdef ARB4TO1_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [3:0]    req   = 4'b0000;
  logic [DW-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0]    gnt;
  logic          sel1, sel0;
  logic [DW-1:0] y;
  logic          valid;

  arb4to1 #(.DATA_W(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_0     (d0),
    .i_1     (d1),
    .i_2     (d2),
    .i_3     (d3),
    .o_gnt   (gnt),
    .o_sel1  (sel1),
    .o_sel0  (sel0),
    .o_y     (y),
    .o_valid (valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner is an integer (-1 = nobody), grant length in cycles.
  int            m_owner  = -1;
  int            m_last   = 3;
  int            m_cycles = 0;
  logic [3:0]    m_gnt    = '0;
  logic [3:0]    m_prev   = '0;
  logic [1:0]    m_sel    = '0;
  logic [DW-1:0] m_y      = '0;
  logic          m_valid  = 1'b0;

  function automatic int rr_next(input logic [3:0] r, input int from, input int skip);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (from + k) % 4;
      if (r[c] && c != skip) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_last = 3; m_cycles = 0;
      m_gnt = '0; m_sel = '0; m_y = '0; m_valid = 1'b0; m_prev = '0;
    end else begin
      int nxt;
      int other;
      logic [DW-1:0] data [4];
      data[0] = d0; data[1] = d1; data[2] = d2; data[3] = d3;
      m_valid = 1'b0;
      if (m_owner < 0) begin
        nxt = rr_next(req, m_last, -1);
      end else if (req[m_owner]) begin
        m_valid = 1'b1;
        m_y     = data[m_owner];
        nxt     = m_owner;
        other   = rr_next(req, m_owner, m_owner);
        if (TIMEOUT && m_cycles >= MAX_HOLD && other >= 0) nxt = other;
      end else begin
        nxt = rr_next(req, m_owner, m_owner);
      end
      if (nxt < 0) begin
        m_owner = -1;
        m_gnt   = '0;
      end else if (nxt == m_owner) begin
        m_cycles++;
      end else begin
        m_owner  = nxt;
        m_last   = nxt;
        m_cycles = 1;
        m_gnt    = 4'(1 << nxt);
        m_sel    = 2'(nxt);
      end
      m_prev = req;
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_gnt", 32'(gnt), 32'(m_gnt));
      chk("model_sel", 32'({sel1, sel0}), 32'(m_sel));
      chk("model_valid", 32'(valid), 32'(m_valid));
      chk("model_y", 32'(y), 32'(m_y));
      chk("onehot_gnt", 32'($countones(gnt) <= 1), 32'd1);
      chk("gnt_low_req", 32'(gnt & ~m_prev), 32'd0);
      if (gnt != 4'b0000) chk("sel_matches_gnt", 32'(4'b0001 << {sel1, sel0}), 32'(gnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; reset is asserted and released before the next edge.
  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_g [9];
    logic [1:0] exp_s [9];
    exp_g = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    exp_s = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cmp_en = 1'b1;
    #1;
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_sel", 32'({sel1, sel0}), 32'd0);
    chk("reset_y", 32'(y), 32'd0);
    chk("reset_valid", 32'(valid), 32'd0);

    // Single requester 0.
    d0 = 2'b01; req = 4'b0001;
    step; chk("single_gnt", 32'(gnt), 32'b0001); chk("single_sel", 32'({sel1, sel0}), 32'd0);
    step; chk("single_valid", 32'(valid), 32'd1); chk("single_y", 32'(y), 32'b01);
    step; req = 4'b0000;
    step; chk("single_idle_gnt", 32'(gnt), 32'd0); chk("single_idle_valid", 32'(valid), 32'd0);
    step;

    // All four requesting, each owner releasing after two grant cycles.
    pulse_reset();
    d0 = 2'd0; d1 = 2'd1; d2 = 2'd2; d3 = 2'd3;
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      step;
      chk($sformatf("rr_gnt_%0d", i), 32'(gnt), 32'(exp_g[i]));
      chk($sformatf("rr_sel_%0d", i), 32'({sel1, sel0}), 32'(exp_s[i]));
      req = (i % 2 == 1) ? (4'b1111 & ~exp_g[i]) : 4'b1111;
    end
    req = 4'b0000; step; step;

    // Owner 2 releases while 3 and 0 wait: 3 comes first.
    req = 4'b0100; step; chk("after2_own", 32'(gnt), 32'b0100);
    req = 4'b1101; step; chk("after2_hold", 32'(gnt), 32'b0100);
    req = 4'b1001; step; chk("after2_next", 32'(gnt), 32'b1000);
    req = 4'b0000; step; step;

    // Asynchronous reset mid-transfer.
    pulse_reset();
    d2 = 2'b11; req = 4'b0100;
    step; chk("arst_pre_gnt", 32'(gnt), 32'b0100);
    step; chk("arst_pre_valid", 32'(valid), 32'd1); chk("arst_pre_y", 32'(y), 32'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_sel", 32'({sel1, sel0}), 32'd0);
    chk("arst_y", 32'(y), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    #1 req = 4'b1010; rst_n = 1'b1;
    step; chk("arst_first_gnt", 32'(gnt), 32'b0010); chk("arst_first_sel", 32'({sel1, sel0}), 32'd1);
    req = 4'b0000; step; step;

`ifdef ARB4TO1_TIMEOUT_EN
    pulse_reset();
    req = 4'b0011;
    for (int k = 0; k < 24; k++) begin
      step;
      chk($sformatf("tmo_alt_%0d", k), 32'(gnt), ((k / 8) % 2 == 0) ? 32'b0001 : 32'b0010);
    end
    req = 4'b0000; step; step;
    pulse_reset();
    req = 4'b0001;
    repeat (12) step;
    chk("tmo_alone_keep", 32'(gnt), 32'b0001);
    req = 4'b0000; step; step;
`endif

    // Randomized traffic with sticky requests and occasional resets.
    for (int n = 0; n < 600; n++) begin
      step;
      d0 = DW'($urandom); d1 = DW'($urandom); d2 = DW'($urandom); d3 = DW'($urandom);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(0, 199) == 0) pulse_reset();
    end
    step;
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arb4to1.md
ARB4TO1 -- requirements
Module: arb4to1

Interface
REQ-001 Parameter: DATA_W, default 2, width of each requester data input and o_y.
REQ-002 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles per owner; used only with ARB4TO1_TIMEOUT_EN.
REQ-003 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_req  in  4  request from requesters 3..0; a requester holds it high for the whole transfer.
REQ-006 i_0, i_1, i_2, i_3  in  DATA_W each  requester data.
REQ-007 o_gnt  out  4  one-hot grant, or all zero when idle.
REQ-008 o_sel1, o_sel0  out  1 each  encoded index of the current owner; drive a downstream 4:1 mux.
REQ-009 o_y  out  DATA_W  registered data of the owner.
REQ-010 o_valid  out  1  o_y carries owner data.

Function
REQ-011 The FSM SHALL have two states: IDLE and GRANT.
REQ-012 IDLE, i_req==0: SHALL stay in IDLE with o_gnt=0.
REQ-013 IDLE, i_req!=0: at the next edge SHALL enter GRANT, granting the first requesting index found searching last_owner+1, +2, +3, +4 (mod 4).
REQ-014 GRANT, owner's i_req high: SHALL hold the grant unchanged.
REQ-015 GRANT, owner's i_req low and other requests pending: at the next edge SHALL grant the next requester in round-robin order (from owner+1), with no idle cycle between grants.
REQ-016 GRANT, owner's i_req low and no requests pending: SHALL return to IDLE at the next edge, with o_gnt=0.
REQ-017 last_owner SHALL update to the owner index on every new grant.
REQ-018 {o_sel1,o_sel0} SHALL equal the index of the one-hot o_gnt bit, and hold their previous value while idle.
REQ-019 o_y/o_valid latency:
- SHALL capture i_<owner> at each edge during which the FSM is in GRANT and the owner's i_req is high.
- o_valid SHALL be 1 the cycle after each such capture and 0 otherwise.
- o_y SHALL hold its last value when o_valid=0.
REQ-020 o_gnt SHALL never have more than one bit set.
REQ-021 A grant SHALL never be issued to a requester whose i_req is low at the deciding edge.
REQ-022 A request that rises in the same cycle the owner releases SHALL be eligible for that decision.

Reset
REQ-023 Asserting i_rst_n low SHALL immediately force the following, regardless of clock: state=IDLE, o_gnt=0000, o_sel1=o_sel0=0, o_y=0, o_valid=0, last_owner=3 (requester 0 has first priority), hold counter=0.
REQ-024 Reset asserted mid-transfer SHALL abort the grant; after release, arbitration SHALL restart per REQ-013.

Configuration
REQ-025 Macro ARB4TO1_TIMEOUT_EN defined: a hold counter SHALL count grant cycles of the current owner.
- When the count reaches MAX_HOLD and any other request is pending, the grant SHALL move at the next edge to the next requester in round-robin order, even though the owner's request is still high.
- The counter SHALL clear on every new grant.
- If no other request is pending, the owner SHALL keep the grant.
REQ-026 Macro undefined: no counter SHALL exist, and a grant SHALL be held as long as the owner requests.

Verification
REQ-027 Reset, then i_req=0001 for 3 cycles with i_0=2'b01:
- one edge later: o_gnt=0001, sel=00;
- the following cycle: o_valid=1, o_y=01;
- after the request drops: IDLE, o_gnt=0000.
REQ-028 i_req=1111 with each requester releasing after 2 grant cycles: grants SHALL go 0001, 0010, 0100, 1000, 0001 with no idle gaps; sel=00, 01, 10, 11.
REQ-029 Owner 2 releases while i_req[0] and i_req[3] are high: the next grant SHALL be 1000 (3 precedes 0 after 2).
REQ-030 Reset pulse while o_gnt=0100 and o_valid=1: all outputs SHALL be zero without a clock edge; after release with i_req=1010, the first grant SHALL be 0010.
REQ-031 ARB4TO1_TIMEOUT_EN, MAX_HOLD=8, i_req=0011 held high: grant SHALL alternate 0001 and 0010, each lasting 8 cycles; with i_req=0001 alone, grant 0001 SHALL persist past 8 cycles.
REQ-032 A checker SHALL run throughout every scenario and confirm: o_gnt has at most one bit set; o_gnt is never set for a low request; the sel pair matches o_gnt.
